menu_controller: RTL and testbench



---
 rtl/menu_controller_if.sv | 34 +++
 rtl/menu_controller.sv | 155 +++++++++++++++
 tb/tb_menu_controller.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/menu_controller_if.sv
// +----------------------------------------------------------------------+
// | menu_controller_if : encoder ticks in, LEDs and config bus out        |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

interface menu_controller_if #(
   parameter int NREG  = 4,
   parameter int WIDTH = 8
);
   logic                    center;
   logic                    left;
   logic                    right;
   logic [7:0]              leds;
   logic                    edit;
   logic [NREG*WIDTH-1:0]   cfg_bus;
   logic                    cfg_we;
   logic [2:0]              cfg_addr;
   logic [WIDTH-1:0]        cfg_data;

   // master: tick sources and configuration consumers
   modport master (
      output center, left, right,
      input  leds, edit, cfg_bus, cfg_we, cfg_addr, cfg_data
   );

   // slave: the menu controller itself
   modport slave (
      input  center, left, right,
      output leds, edit, cfg_bus, cfg_we, cfg_addr, cfg_data
   );
endinterface

`default_nettype wire

// File: rtl/menu_controller.sv
// +----------------------------------------------------------------------+
// | menu_controller : browse/edit menu over a bank of config registers   |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module menu_controller #(
   parameter int NREG      = 4,
   parameter int WIDTH     = 8,
   parameter int BLINK_DIV = 25_000_000,
   parameter int TIMEOUT   = 500_000_000
) (
   input  logic             clk,
   input  logic             rst,
   menu_controller_if.slave bus
);
   localparam int DIV_W  = $clog2(BLINK_DIV);
   localparam int IDLE_W = $clog2(TIMEOUT);
   localparam int BUS_W  = NREG * WIDTH;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BLINK_DIV - 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [2:0]        SEL_LAST  = 3'(NREG - 1);
   localparam logic [WIDTH-1:0]  SHD_MAX   = '1;

   localparam logic [0:0] ST_BROWSE = 1'b0;
   localparam logic [0:0] ST_EDIT   = 1'b1;

   logic [0:0]        state_q,   state_d;
   logic [2:0]        sel_q,     sel_d;
   logic [WIDTH-1:0]  shd_q,     shd_d;
   logic [BUS_W-1:0]  cfg_bus_q, cfg_bus_d;
   logic              cfg_we_q,  cfg_we_d;
   logic [2:0]        cfg_addr_q, cfg_addr_d;
   logic [WIDTH-1:0]  cfg_data_q, cfg_data_d;
   logic [7:0]        leds_q,    leds_d;
   logic              edit_q,    edit_d;
   logic              hb_q,      hb_d;
   logic [DIV_W-1:0]  div_q,     div_d;
   logic [IDLE_W-1:0] idle_q,    idle_d;

   logic              ev_center;
   logic              ev_right;
   logic              ev_left;
   logic              ev_any;
   logic [WIDTH-1:0]  cur_reg;

   // center wins; a simultaneous left/right pair cancels but still counts as activity
   assign ev_center = bus.center;
   assign ev_right  = bus.right & ~bus.left & ~bus.center;
   assign ev_left   = bus.left & ~bus.right & ~bus.center;
   assign ev_any    = bus.center | bus.left | bus.right;
   assign cur_reg   = cfg_bus_q[int'(sel_q) * WIDTH +: WIDTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_BROWSE;
         sel_q      <= '0;
         shd_q      <= '0;
         cfg_bus_q  <= '0;
         cfg_we_q   <= 1'b0;
         cfg_addr_q <= '0;
         cfg_data_q <= '0;
         leds_q     <= 8'h01;
         edit_q     <= 1'b0;
         hb_q       <= 1'b0;
         div_q      <= '0;
         idle_q     <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         shd_q      <= shd_d;
         cfg_bus_q  <= cfg_bus_d;
         cfg_we_q   <= cfg_we_d;
         cfg_addr_q <= cfg_addr_d;
         cfg_data_q <= cfg_data_d;
         leds_q     <= leds_d;
         edit_q     <= edit_d;
         hb_q       <= hb_d;
         div_q      <= div_d;
         idle_q     <= idle_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      shd_d      = shd_q;
      cfg_bus_d  = cfg_bus_q;
      cfg_we_d   = 1'b0;
      cfg_addr_d = cfg_addr_q;
      cfg_data_d = cfg_data_q;
      idle_d     = '0;

      if (div_q == DIV_LAST) begin
         div_d = '0;
         hb_d  = ~hb_q;
      end else begin
         div_d = div_q + 1'b1;
         hb_d  = hb_q;
      end

      case (state_q)
         ST_BROWSE: begin
            if (ev_center) begin
               shd_d   = cur_reg;
               state_d = ST_EDIT;
            end else if (ev_right) begin
               sel_d = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
            end else if (ev_left) begin
               sel_d = (sel_q == 3'd0) ? SEL_LAST : sel_q - 3'd1;
            end
         end
         default: begin
            if (ev_center) begin
               cfg_bus_d[int'(sel_q) * WIDTH +: WIDTH] = shd_q;
               cfg_we_d   = 1'b1;
               cfg_addr_d = sel_q;
               cfg_data_d = shd_q;
               state_d    = ST_BROWSE;
            end else if (ev_any) begin
               if (ev_right && shd_q != SHD_MAX) begin
                  shd_d = shd_q + 1'b1;
               end else if (ev_left && shd_q != '0) begin
                  shd_d = shd_q - 1'b1;
               end
            end else if (idle_q == IDLE_LAST) begin
               state_d = ST_BROWSE;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
      endcase
   end

   // outputs are computed from next state so they appear together with it
   always_comb begin
      edit_d = (state_d == ST_EDIT);
      if (state_d == ST_EDIT) begin
         leds_d = shd_d;
      end else begin
         leds_d = {hb_d, 7'(7'd1 << sel_d)};
      end
   end

   assign bus.leds     = leds_q;
   assign bus.edit     = edit_q;
   assign bus.cfg_bus  = cfg_bus_q;
   assign bus.cfg_we   = cfg_we_q;
   assign bus.cfg_addr = cfg_addr_q;
   assign bus.cfg_data = cfg_data_q;

endmodule

`default_nettype wire

// File: tb/tb_menu_controller.sv
// Bench for menu_controller: directed plan with literal expectations plus
// randomized ticks against a rule-level reference model.
`default_nettype none

module tb_menu_controller;
   localparam int NREG      = 4;
   localparam int WIDTH     = 8;
   localparam int BLINK_DIV = 4;
   localparam int TIMEOUT   = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   menu_controller_if #(.NREG(NREG), .WIDTH(WIDTH)) bus ();

   menu_controller #(
      .NREG(NREG), .WIDTH(WIDTH), .BLINK_DIV(BLINK_DIV), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit m_valid = 0;
   bit m_rstd  = 0;
   bit m_edit  = 0;
   int m_sel   = 0;
   int m_shd   = 0;
   int m_idle  = 0;
   int m_t     = 0;
   int m_regs[NREG];
   bit e_we    = 0;
   int e_addr  = 0;
   int e_data  = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1; m_rstd = 1; m_edit = 0; m_sel = 0; m_shd = 0;
         m_idle = 0; m_t = 0; e_we = 0; e_addr = 0; e_data = 0;
         foreach (m_regs[i]) m_regs[i] = 0;
      end else begin
         m_rstd = 0;
         m_t++;
         e_we = 0;
         if (bus.center) begin
            if (!m_edit) begin
               m_shd = m_regs[m_sel]; m_edit = 1; m_idle = 0;
            end else begin
               m_regs[m_sel] = m_shd;
               e_we = 1; e_addr = m_sel; e_data = m_shd;
               m_edit = 0;
            end
         end else if (m_edit) begin
            if (bus.left || bus.right) begin
               m_idle = 0;
               if (bus.right && !bus.left) m_shd = (m_shd + 1 > 255) ? 255 : m_shd + 1;
               if (bus.left && !bus.right) m_shd = (m_shd - 1 < 0) ? 0 : m_shd - 1;
            end else if (m_idle == TIMEOUT - 1) begin
               m_edit = 0; m_idle = 0;
            end else begin
               m_idle++;
            end
         end else begin
            if (bus.right && !bus.left) m_sel = (m_sel + 1) % NREG;
            if (bus.left && !bus.right) m_sel = (m_sel + NREG - 1) % NREG;
         end
      end
   end

   always @(negedge clk) begin
      logic [7:0]  el;
      logic [31:0] eb;
      if (m_valid) begin
         if (m_edit) el = 8'(m_shd);
         else        el = {1'((m_t / BLINK_DIV) % 2), 7'(1 << m_sel)};
         eb = '0;
         for (int i = 0; i < NREG; i++) eb[i*8 +: 8] = 8'(m_regs[i]);
         chk("leds", {24'd0, bus.leds}, {24'd0, el});
         chk("edit", {31'd0, bus.edit}, {31'd0, m_edit});
         chk("cfg_we", {31'd0, bus.cfg_we}, {31'd0, e_we});
         chk("cfg_bus", bus.cfg_bus, eb);
         if (e_we || m_rstd) begin
            chk("cfg_addr", {29'd0, bus.cfg_addr}, 32'(e_addr));
            chk("cfg_data", {24'd0, bus.cfg_data}, 32'(e_data));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit c, input bit l, input bit r);
      bus.center = c;
      bus.left   = l;
      bus.right  = r;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] sel_pat [5];
      sel_pat[0] = 8'h02; sel_pat[1] = 8'h04; sel_pat[2] = 8'h08;
      sel_pat[3] = 8'h01; sel_pat[4] = 8'h02;
      bus.center = 0; bus.left = 0; bus.right = 0;
      @(negedge clk);
      rst = 1; idle(2); rst = 0;
      chk("lit_reset_leds", {24'd0, bus.leds}, 32'h01);
      chk("lit_reset_bus", bus.cfg_bus, 32'h0);

      // heartbeat: k cycles after the last reset edge
      for (int k = 1; k <= 16; k++) begin
         step(0, 0, 0);
         chk("lit_heartbeat", {31'd0, bus.leds[7]}, 32'((k / 4) % 2));
      end

      for (int k = 0; k < 5; k++) begin
         step(0, 0, 1);
         chk("lit_sel_right", {24'd0, bus.leds & 8'h7f}, {24'd0, sel_pat[k]});
      end
      step(0, 1, 0); chk("lit_sel_left0", {24'd0, bus.leds & 8'h7f}, 32'h01);
      step(0, 1, 0); chk("lit_sel_wrap",  {24'd0, bus.leds & 8'h7f}, 32'h08);
      step(0, 1, 0); chk("lit_sel2",      {24'd0, bus.leds & 8'h7f}, 32'h04);

      step(1, 0, 0); chk("lit_enter_edit", {31'd0, bus.edit}, 32'h1);
      idle(0);
      for (int k = 0; k < 3; k++) step(0, 0, 1);
      chk("lit_shd3", {24'd0, bus.leds}, 32'h03);
      step(1, 0, 0);
      chk("lit_commit_we",   {31'd0, bus.cfg_we}, 32'h1);
      chk("lit_commit_addr", {29'd0, bus.cfg_addr}, 32'h2);
      chk("lit_commit_data", {24'd0, bus.cfg_data}, 32'h3);
      chk("lit_commit_bus",  bus.cfg_bus, 32'h0003_0000);
      chk("lit_commit_edit", {31'd0, bus.edit}, 32'h0);
      chk("lit_commit_leds", {24'd0, bus.leds & 8'h7f}, 32'h04);
      step(0, 0, 0); chk("lit_we_single", {31'd0, bus.cfg_we}, 32'h0);

      // saturation on register 3
      step(0, 0, 1); step(1, 0, 0);
      step(0, 1, 0); step(0, 1, 0);
      chk("lit_sat_low", {24'd0, bus.leds}, 32'h00);
      for (int k = 0; k < 255; k++) step(0, 0, 1);
      chk("lit_255", {24'd0, bus.leds}, 32'hff);
      step(1, 0, 0); step(1, 0, 0); step(0, 0, 1);
      chk("lit_sat_high", {24'd0, bus.leds}, 32'hff);
      step(1, 0, 0);

      // simultaneous events
      step(1, 0, 1); chk("lit_center_right", {31'd0, bus.edit}, 32'h1);
      idle(10);
      step(0, 1, 1); chk("lit_pair_noop", {24'd0, bus.leds}, 32'hff);
      idle(15); chk("lit_pair_clears_idle", {31'd0, bus.edit}, 32'h1);
      idle(1);  chk("lit_abort_after_pair", {31'd0, bus.edit}, 32'h0);
      chk("lit_sel_kept", {24'd0, bus.leds & 8'h7f}, 32'h08);

      // timeout discards shadow
      step(0, 1, 0); step(1, 0, 0); step(0, 0, 1); step(0, 0, 1);
      chk("lit_shd5", {24'd0, bus.leds}, 32'h05);
      idle(15); chk("lit_pre_timeout", {31'd0, bus.edit}, 32'h1);
      idle(1);  chk("lit_timeout", {31'd0, bus.edit}, 32'h0);
      chk("lit_timeout_bus", bus.cfg_bus, 32'hff03_0000);
      chk("lit_timeout_leds", {24'd0, bus.leds & 8'h7f}, 32'h04);

      // reset mid-edit
      step(1, 0, 0); step(0, 0, 1);
      rst = 1; step(0, 0, 0);
      chk("lit_rst_leds", {24'd0, bus.leds}, 32'h01);
      chk("lit_rst_edit", {31'd0, bus.edit}, 32'h0);
      chk("lit_rst_bus", bus.cfg_bus, 32'h0);
      chk("lit_rst_we", {31'd0, bus.cfg_we}, 32'h0);
      chk("lit_rst_addr", {29'd0, bus.cfg_addr}, 32'h0);
      chk("lit_rst_data", {24'd0, bus.cfg_data}, 32'h0);
      rst = 0;

      // randomized ticks
      for (int n = 0; n < 3000; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if ($urandom_range(0, 999) == 0) begin
            rst = 1; step(0, 0, 0); rst = 0;
         end else if (r < 3) begin
            idle(int'($urandom_range(10, 20)));
         end else if (r < 12) begin
            step(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
         end else if (r < 16) begin
            step(0, 1, 1);
         end else if (r < 45) begin
            step(0, 0, 1);
         end else if (r < 70) begin
            step(0, 1, 0);
         end else begin
            step(0, 0, 0);
         end
      end
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
